fan_pwm_gen: RTL and testbench

Fan PWM output stage. Sits directly downstream of the PI controller inside the fan-control top level: it consumes the signed controller output every PWM period and drives the PWM pin. It clamps and maps the controller value to a duty cycle, updates the duty only at period boundaries so the output never glitches, and applies a full-on kick-start when the fan starts from standstill.

---
 rtl/fan_pwm_gen.sv | 188 ++++++++++++++++++
 tb/tb_fan_pwm_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fan_pwm_gen.sv
// -----------------------------------------------------------------------------
// fan_pwm_gen
//
// Fan PWM output stage. Takes the signed PI-controller output once per PWM
// period, clamps it to a duty cycle in steps, and drives the PWM pin. The duty
// is only updated at period boundaries so the pin never glitches mid-period.
// A start from standstill is preceded by KICK_PERIODS full-on periods to get
// the rotor moving before the regulated duty is applied.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   ena            in   clock enable; when low every register holds
//   pid_val_i      in   signed controller output, PID_BITWIDTH bits
//   pwm_o          out  PWM pin (registered)
//   duty_o         out  currently applied duty in steps (0 in STOPPED/KICK)
//   period_start_o out  one-cycle pulse in the first clock of each period
//   kick_active_o  out  high while the kick-start is running
// -----------------------------------------------------------------------------
module fan_pwm_gen #(
  parameter int PID_BITWIDTH = 5,
  parameter int PWM_BITWIDTH = 4,
  parameter int PRESCALE_DIV = 2,
  parameter int MIN_DUTY     = 3,
  parameter int KICK_PERIODS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [PID_BITWIDTH-1:0] pid_val_i,
  output logic                    pwm_o,
  output logic [PWM_BITWIDTH-1:0] duty_o,
  output logic                    period_start_o,
  output logic                    kick_active_o
);

  localparam int STEP_MAX = (1 << PWM_BITWIDTH) - 1;
  localparam int PRESC_W  = (PRESCALE_DIV > 0) ? $clog2(PRESCALE_DIV + 1) : 1;
  localparam int KICK_W   = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;

  // Comparison width: one bit wider than the controller value, widened further
  // if the duty range would not otherwise fit as a positive signed number.
  localparam int CMP_W = ((PID_BITWIDTH > PWM_BITWIDTH + 1) ? PID_BITWIDTH : PWM_BITWIDTH + 1) + 1;

  localparam logic signed [CMP_W-1:0]   ZERO_C    = '0;
  localparam logic signed [CMP_W-1:0]   MIN_C     = CMP_W'(MIN_DUTY);
  localparam logic signed [CMP_W-1:0]   MAX_C     = CMP_W'(STEP_MAX);
  localparam logic [PRESC_W-1:0]        PRESC_MAX = PRESC_W'(PRESCALE_DIV);
  localparam logic [PWM_BITWIDTH-1:0]   STEP_TOP  = '1;
  localparam logic [PWM_BITWIDTH-1:0]   MIN_D     = PWM_BITWIDTH'(MIN_DUTY);
  localparam logic [KICK_W-1:0]         KICK_LOAD = KICK_W'(KICK_PERIODS - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_KICK    = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Clamp the signed controller value into the usable duty range:
  // non-positive -> off, small positive -> minimum spin duty, large -> max.
  function automatic logic [PWM_BITWIDTH-1:0] map_target(
    input logic signed [PID_BITWIDTH-1:0] pid
  );
    logic signed [CMP_W-1:0] ext;
    ext = CMP_W'(pid);
    if (ext <= ZERO_C) begin
      return '0;
    end else if (ext < MIN_C) begin
      return MIN_D;
    end else if (ext > MAX_C) begin
      return STEP_TOP;
    end else begin
      return PWM_BITWIDTH'(ext);
    end
  endfunction

  // Registered state
  state_t                  state;
  logic [PRESC_W-1:0]      presc_cnt;
  logic [PWM_BITWIDTH-1:0] step_cnt;
  logic [PWM_BITWIDTH-1:0] duty_q;
  logic [KICK_W-1:0]       kick_cnt;
  logic                    pwm_q;
  logic                    period_start_q;
  logic                    kick_active_q;

  // Next-state values
  state_t                  state_n;
  logic [PRESC_W-1:0]      presc_n;
  logic [PWM_BITWIDTH-1:0] step_n;
  logic [PWM_BITWIDTH-1:0] duty_n;
  logic [KICK_W-1:0]       kick_n;
  logic                    pwm_n;
  logic                    boundary;
  logic [PWM_BITWIDTH-1:0] target;

  assign target = map_target($signed(pid_val_i));

  always_comb begin
    state_n  = state;
    presc_n  = presc_cnt;
    step_n   = step_cnt;
    duty_n   = duty_q;
    kick_n   = kick_cnt;
    pwm_n    = 1'b0;
    boundary = ena && (presc_cnt == PRESC_MAX) && (step_cnt == STEP_TOP);

    // Step counter wraps naturally at 2^PWM_BITWIDTH.
    if (presc_cnt == PRESC_MAX) begin
      presc_n = '0;
      step_n  = step_cnt + 1'b1;
    end else begin
      presc_n = presc_cnt + 1'b1;
    end

    // The controller value is only looked at here, so a mid-period change
    // can never disturb the period currently being generated.
    if (boundary) begin
      case (state)
        ST_STOPPED: begin
          if (target != '0) begin
            state_n = ST_KICK;
            kick_n  = KICK_LOAD;
          end
        end
        ST_KICK: begin
          if (target == '0) begin
            state_n = ST_STOPPED;
            duty_n  = '0;
          end else if (kick_cnt == '0) begin
            state_n = ST_RUN;
            duty_n  = target;
          end else begin
            kick_n = kick_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (target == '0) begin
            state_n = ST_STOPPED;
            duty_n  = '0;
          end else begin
            duty_n = target;
          end
        end
        default: begin
          state_n = ST_STOPPED;
          duty_n  = '0;
        end
      endcase
    end

    // The pin is computed from next-state values so the registered output
    // lines up with the registered counters in the same clock.
    case (state_n)
      ST_KICK: pwm_n = 1'b1;
      ST_RUN:  pwm_n = (step_n < duty_n);
      default: pwm_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_STOPPED;
      presc_cnt      <= '0;
      step_cnt       <= '0;
      duty_q         <= '0;
      kick_cnt       <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      kick_active_q  <= 1'b0;
    end else if (ena) begin
      state          <= state_n;
      presc_cnt      <= presc_n;
      step_cnt       <= step_n;
      duty_q         <= duty_n;
      kick_cnt       <= kick_n;
      pwm_q          <= pwm_n;
      period_start_q <= boundary;
      kick_active_q  <= (state_n == ST_KICK);
    end
  end

  assign pwm_o          = pwm_q;
  assign duty_o         = duty_q;
  assign period_start_o = period_start_q;
  assign kick_active_o  = kick_active_q;

endmodule

// File: tb/tb_fan_pwm_gen.sv
module tb_fan_pwm_gen;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic signed [4:0] pid_val_i;
  logic              pwm_o;
  logic [3:0]        duty_o;
  logic              period_start_o;
  logic              kick_active_o;

  int nvec  = 0;
  int nfail = 0;

  fan_pwm_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .pid_val_i      (pid_val_i),
    .pwm_o          (pwm_o),
    .duty_o         (duty_o),
    .period_start_o (period_start_o),
    .kick_active_o  (kick_active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [4:0] pid;
    int                duty;
    int                hi;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts on the currently sampled cycle and counts samples until the next
  // period_start_o. Optionally changes pid at index chg_at and drops ena for
  // frz_len clocks after index frz_at, checking that all outputs hold.
  task automatic measure(input int chg_at, input logic signed [4:0] chg_pid,
                         input int frz_at, input int frz_len,
                         output int hi, output int len);
    logic       h_pwm, h_ps, h_ka;
    logic [3:0] h_duty;
    int         held_bad;
    hi = 0; len = 0; held_bad = 0;
    h_pwm = 1'b0; h_ps = 1'b0; h_ka = 1'b0; h_duty = '0;
    forever begin
      hi += int'(pwm_o);
      len++;
      if (frz_at >= 0 && (len - 1) > frz_at && (len - 1) <= frz_at + frz_len) begin
        if (pwm_o !== h_pwm || period_start_o !== h_ps ||
            kick_active_o !== h_ka || duty_o !== h_duty) held_bad++;
      end
      if ((len - 1) == chg_at) pid_val_i = chg_pid;
      if ((len - 1) == frz_at) begin
        h_pwm = pwm_o; h_ps = period_start_o; h_ka = kick_active_o; h_duty = duty_o;
        ena = 1'b0;
      end
      if (frz_at >= 0 && (len - 1) == frz_at + frz_len) ena = 1'b1;
      tick();
      if (period_start_o && !(frz_at >= 0 && (len - 1) >= frz_at && (len - 1) < frz_at + frz_len))
        break;
      if (len > 400) begin
        nvec++; nfail++;
        $display("FAIL period_timeout: got %0d clocks without period start, expected at most 400", len);
        break;
      end
    end
    if (frz_at >= 0) chk("freeze_hold", held_bad, 0);
  endtask

  // At the first clock of the first kick period: checks the four kick periods
  // and the first RUN period with duty 5.
  task automatic kick_then_run(input string tag);
    int hi, len, tot_hi, tot_len;
    tot_hi = 0; tot_len = 0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_kick_active"}, int'(kick_active_o), 1);
      chk({tag, "_kick_duty"}, int'(duty_o), 0);
      measure(-1, 5'sd0, -1, 0, hi, len);
      tot_hi += hi; tot_len += len;
    end
    chk({tag, "_kick_high"}, tot_hi, 192);
    chk({tag, "_kick_len"}, tot_len, 192);
    chk({tag, "_run_kick_off"}, int'(kick_active_o), 0);
    chk({tag, "_run_duty"}, int'(duty_o), 5);
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk({tag, "_run_high"}, hi, 15);
    chk({tag, "_run_len"}, len, 48);
  endtask

  initial begin
    int hi, len;

    vecs[0] = '{5'sd5,  5,  15};
    vecs[1] = '{5'sd1,  3,  9};
    vecs[2] = '{5'sd2,  3,  9};
    vecs[3] = '{5'sd3,  3,  9};
    vecs[4] = '{5'sd4,  4,  12};
    vecs[5] = '{5'sd15, 15, 45};
    vecs[6] = '{5'sd14, 14, 42};
    vecs[7] = '{5'sd7,  7,  21};
    vecs[8] = '{5'sd5,  5,  15};

    // Reset and idle
    rst_n = 1'b0; ena = 1'b1; pid_val_i = 5'sd7;
    repeat (5) tick();
    chk("rst_pwm", int'(pwm_o), 0);
    chk("rst_duty", int'(duty_o), 0);
    chk("rst_pstart", int'(period_start_o), 0);
    chk("rst_kick", int'(kick_active_o), 0);
    rst_n = 1'b1; pid_val_i = 5'sd0;
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk("idle_first_len", len, 48);
    chk("idle_first_high", hi, 0);
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk("idle_len", len, 48);
    chk("idle_high", hi, 0);

    // Kick then run: pid raised during a STOPPED period
    measure(0, 5'sd5, -1, 0, hi, len);
    chk("stop_period_high", hi, 0);
    kick_then_run("start");

    // Mapping table while in RUN
    foreach (vecs[i]) begin
      measure(3, vecs[i].pid, -1, 0, hi, len);
      chk($sformatf("vec%0d_duty", i), int'(duty_o), vecs[i].duty);
      chk($sformatf("vec%0d_kick", i), int'(kick_active_o), 0);
      measure(-1, 5'sd0, -1, 0, hi, len);
      chk($sformatf("vec%0d_high", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_len", i), len, 48);
    end

    // Stop on negative, changed mid-period: current period is untouched
    measure(10, -5'sd8, -1, 0, hi, len);
    chk("neg8_last_high", hi, 15);
    chk("neg8_duty", int'(duty_o), 0);
    chk("neg8_kick", int'(kick_active_o), 0);
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk("neg8_stopped_high", hi, 0);
    measure(0, 5'sd5, -1, 0, hi, len);
    kick_then_run("restart1");
    measure(10, -5'sd16, -1, 0, hi, len);
    chk("neg16_last_high", hi, 15);
    chk("neg16_duty", int'(duty_o), 0);
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk("neg16_stopped_high", hi, 0);

    // Enable freeze inside and outside the high phase
    measure(0, 5'sd5, -1, 0, hi, len);
    kick_then_run("restart2");
    measure(-1, 5'sd0, 7, 20, hi, len);
    chk("frz_high_phase_high", hi, 35);
    chk("frz_high_phase_len", len, 68);
    measure(-1, 5'sd0, 31, 20, hi, len);
    chk("frz_low_phase_high", hi, 15);
    chk("frz_low_phase_len", len, 68);
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk("after_frz_high", hi, 15);
    chk("after_frz_len", len, 48);

    // Reset in the middle of the second kick period
    measure(0, 5'sd0, -1, 0, hi, len);
    chk("to_stop_duty", int'(duty_o), 0);
    measure(0, 5'sd5, -1, 0, hi, len);
    chk("k1_active", int'(kick_active_o), 1);
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk("k1_high", hi, 48);
    chk("k2_active", int'(kick_active_o), 1);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("midkick_rst_pwm", int'(pwm_o), 0);
    chk("midkick_rst_duty", int'(duty_o), 0);
    chk("midkick_rst_pstart", int'(period_start_o), 0);
    chk("midkick_rst_kick", int'(kick_active_o), 0);
    rst_n = 1'b1;
    measure(-1, 5'sd0, -1, 0, hi, len);
    chk("post_rst_stop_high", hi, 0);
    chk("post_rst_stop_len", len, 48);
    kick_then_run("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
